ysyx_23060201_exu_mc: RTL and testbench

Multi-cycle execute unit, the handshaked successor of the single-cycle EXU. It sits between IDU and WBU and accepts one decoded instruction per valid/ready handshake. It drives a request/response memory port for loads and stores, with byte-lane alignment and misalignment detection. It returns a registered writeback/redirect packet, and is parametrised for RV32/RV64 data width with an optional iterative (1 bit/cycle) shifter.

---
 rtl/ysyx_23060201_exu_mc.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_ysyx_23060201_exu_mc.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_exu_mc.sv
// ============================================================================
//  Module   : ysyx_23060201_exu_mc
//  Purpose  : Multi-cycle execute unit placed between IDU and WBU. It accepts
//             one decoded instruction per valid/ready handshake and runs the
//             ALU, branch and jump logic. Loads and stores go through a
//             request/response memory port with byte-lane alignment and
//             misalignment detection. It returns a registered
//             writeback/redirect packet. An optional iterative shifter
//             processes one bit per cycle.
//  Ports    : clk/rst                  - clock, synchronous active-high reset
//             in_valid/in_ready + pc, imm, op, rd, func3, func7, rs1, rs2
//                                      - decoded instruction handshake
//             mem_req_* / mem_resp_*   - memory request/response port
//             out_valid/out_ready + gpr_*, jump_en, dnpc, misalign
//                                      - writeback/redirect packet
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060201_exu_mc #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ITER_SHIFT     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0]     imm,
    input  logic [6:0]                op,
    input  logic [4:0]                rd,
    input  logic [2:0]                func3,
    input  logic [6:0]                func7,
    input  logic [DATA_WIDTH-1:0]     rs1,
    input  logic [DATA_WIDTH-1:0]     rs2,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_wen,
    output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH/8-1:0]   mem_req_wmask,
    output logic [DATA_WIDTH-1:0]     mem_req_wdata,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_resp_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      gpr_wen,
    output logic [4:0]                gpr_waddr,
    output logic [DATA_WIDTH-1:0]     gpr_wdata,
    output logic                      jump_en,
    output logic [MEM_ADDR_WIDTH-1:0] dnpc,
    output logic                      misalign
);

    localparam int c_NB  = DATA_WIDTH / 8;
    localparam int c_NBW = $clog2(c_NB);
    localparam int c_SHW = $clog2(DATA_WIDTH);

    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_I   = 7'b0010011;
    localparam logic [6:0] c_OP_IL  = 7'b0000011;
    localparam logic [6:0] c_OP_S   = 7'b0100011;
    localparam logic [6:0] c_OP_B   = 7'b1100011;
    localparam logic [6:0] c_OP_J   = 7'b1101111;
    localparam logic [6:0] c_OP_JR  = 7'b1100111;
    localparam logic [6:0] c_OP_U   = 7'b0110111;
    localparam logic [6:0] c_OP_UPC = 7'b0010111;

    localparam logic [c_SHW-1:0] c_CNT_ONE = c_SHW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_MREQ  = 3'd2,
        S_MWAIT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    // Registered packet / request fields and in-flight bookkeeping
    logic                      r_gpr_wen, r_jump_en, r_misalign, r_mem_wen;
    logic [4:0]                r_gpr_waddr;
    logic [DATA_WIDTH-1:0]     r_gpr_wdata, r_mem_wdata, r_shv;
    logic [MEM_ADDR_WIDTH-1:0] r_dnpc, r_mem_addr;
    logic [c_NB-1:0]           r_mem_wmask;
    logic [c_NBW-1:0]          r_off;
    logic [1:0]                r_ld_sz, r_sh_kind;
    logic                      r_ld_sgn;
    logic [c_SHW-1:0]          r_cnt;

    // Combinational decode/execute of the instruction being accepted
    logic                      w_accept, w_is_mem, w_is_shift, w_sub, w_lt, w_ltu;
    logic                      w_taken, w_mis, w_wen, w_ld_sgn, w_fill;
    logic [DATA_WIDTH-1:0]     w_b, w_alu, w_wb, w_ea, w_pc_ext, w_ld_sh, w_ld, w_shv_nxt;
    logic [MEM_ADDR_WIDTH-1:0] w_pc4, w_pcimm, w_addr, w_jr, w_dnpc;
    logic [c_SHW-1:0]          w_shamt;
    logic [1:0]                w_sz;
    logic [c_NB-1:0]           w_bmask;
    logic [c_NBW-1:0]          w_off;
    int                        w_nbits;

    assign w_accept = in_valid && (r_state == S_IDLE);

    // ------------------------------------------------------------------
    // ALU, branch, jump and address generation on the raw inputs
    // ------------------------------------------------------------------
    always_comb begin
        w_b        = (op == c_OP_R) ? rs2 : imm;
        w_shamt    = w_b[c_SHW-1:0];
        w_sub      = (op == c_OP_R) && (func7 == 7'b0100000);
        w_lt       = $signed(rs1) < $signed(w_b);
        w_ltu      = rs1 < w_b;
        w_is_shift = ((op == c_OP_R) || (op == c_OP_I)) &&
                     ((func3 == 3'b001) || (func3 == 3'b101));
        w_alu      = '0;
        case (func3)
            3'b000:  w_alu = w_sub ? (rs1 - w_b) : (rs1 + w_b);
            3'b001:  w_alu = rs1 << w_shamt;
            3'b010:  w_alu[0] = w_lt;
            3'b011:  w_alu[0] = w_ltu;
            3'b100:  w_alu = rs1 ^ w_b;
            3'b101:  w_alu = func7[5] ? DATA_WIDTH'($signed(rs1) >>> w_shamt)
                                      : (rs1 >> w_shamt);
            3'b110:  w_alu = rs1 | w_b;
            default: w_alu = rs1 & w_b;
        endcase

        // Branch compare always uses rs2 regardless of the immediate path
        case (func3)
            3'b000:  w_taken = (rs1 == rs2);
            3'b001:  w_taken = (rs1 != rs2);
            3'b100:  w_taken = $signed(rs1) < $signed(rs2);
            3'b101:  w_taken = !($signed(rs1) < $signed(rs2));
            3'b110:  w_taken = rs1 < rs2;
            3'b111:  w_taken = !(rs1 < rs2);
            default: w_taken = 1'b0;
        endcase

        w_pc_ext = DATA_WIDTH'(pc);
        w_pc4    = pc + MEM_ADDR_WIDTH'(4);
        w_pcimm  = pc + MEM_ADDR_WIDTH'(imm);
        w_ea     = rs1 + imm;
        w_addr   = MEM_ADDR_WIDTH'(w_ea);
        w_jr     = w_addr;
        w_jr[0]  = 1'b0;
        w_off    = w_ea[c_NBW-1:0];

        // Access size as log2(bytes); undefined encodings fall back to word
        w_sz = 2'd2;
        case (func3[1:0])
            2'b00:   w_sz = 2'd0;
            2'b01:   w_sz = 2'd1;
            2'b11:   if ((DATA_WIDTH == 64) && !func3[2]) w_sz = 2'd3;
            default: w_sz = 2'd2;
        endcase
        w_ld_sgn = !(func3[2] && (func3 != 3'b111));
        w_mis    = ((w_sz == 2'd1) && w_ea[0]) ||
                   ((w_sz == 2'd2) && (w_ea[1:0] != 2'b00)) ||
                   ((w_sz == 2'd3) && (w_ea[2:0] != 3'b000));
        w_is_mem = (op == c_OP_IL) || (op == c_OP_S);

        for (int i = 0; i < c_NB; i++) begin
            w_bmask[i] = (i < (1 << w_sz));
        end

        w_wen   = 1'b0;
        w_wb    = '0;
        w_dnpc  = w_pc4;
        case (op)
            c_OP_R, c_OP_I: begin w_wen = 1'b1; w_wb = w_alu; end
            c_OP_IL:        w_wen = !w_mis;
            c_OP_U:         begin w_wen = 1'b1; w_wb = imm; end
            c_OP_UPC:       begin w_wen = 1'b1; w_wb = w_pc_ext + imm; end
            c_OP_J:         begin w_wen = 1'b1; w_wb = DATA_WIDTH'(w_pc4); w_dnpc = w_pcimm; end
            c_OP_JR:        begin w_wen = 1'b1; w_wb = DATA_WIDTH'(w_pc4); w_dnpc = w_jr; end
            c_OP_B:         if (w_taken) w_dnpc = w_pcimm;
            default:        w_wen = 1'b0;
        endcase
        if (rd == 5'd0) w_wen = 1'b0;
    end

    // ------------------------------------------------------------------
    // Load extraction from the registered lane offset and size
    // ------------------------------------------------------------------
    always_comb begin
        w_ld_sh = mem_resp_rdata >> {r_off, 3'b000};
        w_nbits = 8 << r_ld_sz;
        w_fill  = r_ld_sgn && w_ld_sh[w_nbits-1];
        w_ld    = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_ld[i] = (i < w_nbits) ? w_ld_sh[i] : w_fill;
        end
    end

    // One-bit step of the iterative shifter: {dir, arith}
    always_comb begin
        case (r_sh_kind)
            2'b00, 2'b01: w_shv_nxt = r_shv << 1;
            2'b10:        w_shv_nxt = r_shv >> 1;
            default:      w_shv_nxt = {r_shv[DATA_WIDTH-1], r_shv[DATA_WIDTH-1:1]};
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        mem_req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_is_mem && !w_mis)
                        w_state_nxt = S_MREQ;
                    else if ((ITER_SHIFT != 0) && w_is_shift && (w_shamt != '0))
                        w_state_nxt = S_SHIFT;
                    else
                        w_state_nxt = S_DONE;
                end
            end
            S_SHIFT: if (r_cnt == c_CNT_ONE) w_state_nxt = S_DONE;
            S_MREQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_state_nxt = S_MWAIT;
            end
            S_MWAIT: if (mem_resp_valid) w_state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpr_wen   <= 1'b0;
            r_gpr_waddr <= '0;
            r_gpr_wdata <= '0;
            r_jump_en   <= 1'b0;
            r_dnpc      <= '0;
            r_misalign  <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wmask <= '0;
            r_mem_wdata <= '0;
            r_off       <= '0;
            r_ld_sz     <= '0;
            r_ld_sgn    <= 1'b0;
            r_shv       <= '0;
            r_cnt       <= '0;
            r_sh_kind   <= '0;
        end else begin
            if (w_accept) begin
                r_gpr_wen   <= w_wen;
                r_gpr_waddr <= rd;
                r_gpr_wdata <= w_wb;
                r_jump_en   <= (op == c_OP_J) || (op == c_OP_JR) ||
                               ((op == c_OP_B) && w_taken);
                r_dnpc      <= w_dnpc;
                r_misalign  <= w_is_mem && w_mis;
                r_off       <= w_off;
                r_ld_sz     <= w_sz;
                r_ld_sgn    <= w_ld_sgn;
                r_shv       <= rs1;
                r_cnt       <= w_shamt;
                r_sh_kind   <= {func3[2], func7[5]};
                if (w_is_mem && !w_mis) begin
                    r_mem_wen   <= (op == c_OP_S);
                    r_mem_addr  <= w_addr & ~MEM_ADDR_WIDTH'(c_NB - 1);
                    r_mem_wmask <= (op == c_OP_S) ? (w_bmask << w_off) : '0;
                    r_mem_wdata <= (op == c_OP_S) ? (rs2 << {w_off, 3'b000}) : '0;
                end
            end
            if (r_state == S_SHIFT) begin
                r_shv <= w_shv_nxt;
                r_cnt <= r_cnt - c_CNT_ONE;
                if (r_cnt == c_CNT_ONE) r_gpr_wdata <= w_shv_nxt;
            end
            if ((r_state == S_MWAIT) && mem_resp_valid && !r_mem_wen)
                r_gpr_wdata <= w_ld;
        end
    end

    assign gpr_wen       = r_gpr_wen;
    assign gpr_waddr     = r_gpr_waddr;
    assign gpr_wdata     = r_gpr_wdata;
    assign jump_en       = r_jump_en;
    assign dnpc          = r_dnpc;
    assign misalign      = r_misalign;
    assign mem_req_wen   = r_mem_wen;
    assign mem_req_addr  = r_mem_addr;
    assign mem_req_wmask = r_mem_wmask;
    assign mem_req_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060201_exu_mc.sv
// ============================================================================
//  Module   : tb_ysyx_23060201_exu_mc
//  Purpose  : Directed self-checking bench for ysyx_23060201_exu_mc
//             (RV32, iterative shifter enabled).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060201_exu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] pc = '0, imm = '0, rs1 = '0, rs2 = '0;
    logic [6:0]  op = '0, func7 = '0;
    logic [4:0]  rd = '0;
    logic [2:0]  func3 = '0;
    logic        mem_req_valid, mem_req_wen;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;
    logic        out_valid, gpr_wen, jump_en, misalign;
    logic        out_ready = 1'b0;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata, dnpc;

    int n_chk  = 0;
    int n_fail = 0;

    ysyx_23060201_exu_mc #(
        .MEM_ADDR_WIDTH (32),
        .DATA_WIDTH     (32),
        .ITER_SHIFT     (1)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .pc             (pc),
        .imm            (imm),
        .op             (op),
        .rd             (rd),
        .func3          (func3),
        .func7          (func7),
        .rs1            (rs1),
        .rs2            (rs2),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wmask  (mem_req_wmask),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .gpr_wen        (gpr_wen),
        .gpr_waddr      (gpr_waddr),
        .gpr_wdata      (gpr_wdata),
        .jump_en        (jump_en),
        .dnpc           (dnpc),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction; returns #1 after the accepting edge
    task automatic issue(input logic [6:0] i_op, input logic [2:0] i_f3, input logic [6:0] i_f7,
                         input logic [4:0] i_rd, input logic [31:0] i_rs1, input logic [31:0] i_rs2,
                         input logic [31:0] i_imm, input logic [31:0] i_pc);
        op = i_op; func3 = i_f3; func7 = i_f7; rd = i_rd;
        rs1 = i_rs1; rs2 = i_rs2; imm = i_imm; pc = i_pc;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Accept the packet and confirm return to IDLE
    task automatic drain(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_idle_ready"}, in_ready, 1);
        chk({tag, "_idle_ovalid"}, out_valid, 0);
    endtask

    // Bounded wait for the request, then handshake and return rdata
    task automatic mem_txn(input string tag, input logic [31:0] rdata);
        int n = 0;
        while (!mem_req_valid && n < 20) begin step(); n++; end
        chk({tag, "_req_seen"}, mem_req_valid, 1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        step();
        mem_resp_valid = 1'b0;
    endtask

    // Count cycles from acceptance until out_valid (1 = next cycle)
    task automatic latency(output int n);
        n = 1;
        while (!out_valid && n < 100) begin step(); n++; end
    endtask

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_IL = 7'b0000011,
                           OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JR = 7'b1100111,
                           OP_UPC = 7'b0010111;

    initial begin
        int lat;

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_wen", gpr_wen, 0);
        chk("rst_wdata", gpr_wdata, 0);
        chk("rst_dnpc", dnpc, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_wmask", mem_req_wmask, 0);

        // ADD with overflow wrap, then back-pressure
        issue(OP_R, 3'b000, 7'h00, 5'd5, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h100);
        chk("add_ovalid", out_valid, 1);
        chk("add_wdata", gpr_wdata, 32'h8000_0000);
        chk("add_wen", gpr_wen, 1);
        chk("add_waddr", gpr_waddr, 5);
        chk("add_dnpc", dnpc, 32'h104);
        chk("add_jump", jump_en, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("add_hold_ovalid", out_valid, 1);
            chk("add_hold_ready", in_ready, 0);
            chk("add_hold_wdata", gpr_wdata, 32'h8000_0000);
            chk("add_hold_dnpc", dnpc, 32'h104);
        end
        drain("add");

        // SUB
        issue(OP_R, 3'b000, 7'b0100000, 5'd6, 32'd5, 32'd7, 32'h0, 32'h108);
        chk("sub_wdata", gpr_wdata, 32'hFFFF_FFFE);
        drain("sub");

        // SLTIU 5 < 0xFFFFFFFF, rd=0 suppresses write
        issue(OP_I, 3'b011, 7'h00, 5'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h10C);
        chk("sltiu_wdata", gpr_wdata, 1);
        chk("sltiu_wen_rd0", gpr_wen, 0);
        drain("sltiu");

        // Iterative SRA by 31
        issue(OP_R, 3'b101, 7'b0100000, 5'd7, 32'h8000_0000, 32'd31, 32'h0, 32'h110);
        latency(lat);
        chk("sra31_latency", lat, 32);
        chk("sra31_wdata", gpr_wdata, 32'hFFFF_FFFF);
        drain("sra31");

        // SRA by 0: single-cycle path
        issue(OP_R, 3'b101, 7'b0100000, 5'd7, 32'h8000_0000, 32'd0, 32'h0, 32'h114);
        latency(lat);
        chk("sra0_latency", lat, 1);
        chk("sra0_wdata", gpr_wdata, 32'h8000_0000);
        drain("sra0");

        // SLLI by 4
        issue(OP_I, 3'b001, 7'h00, 5'd8, 32'h1, 32'h0, 32'd4, 32'h118);
        latency(lat);
        chk("slli4_latency", lat, 5);
        chk("slli4_wdata", gpr_wdata, 32'h10);
        drain("slli4");

        // SB to lane 3 with delayed ready
        issue(OP_S, 3'b000, 7'h00, 5'd0, 32'h1000, 32'hAB, 32'd3, 32'h200);
        for (int i = 0; i < 3; i++) begin
            chk("sb_req_valid", mem_req_valid, 1);
            chk("sb_req_wen", mem_req_wen, 1);
            chk("sb_req_addr", mem_req_addr, 32'h1000);
            chk("sb_req_wmask", mem_req_wmask, 4'b1000);
            chk("sb_req_wdata", mem_req_wdata, 32'hAB00_0000);
            chk("sb_ovalid_wait", out_valid, 0);
            if (i < 2) step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("sb_req_dropped", mem_req_valid, 0);
        chk("sb_mwait_ovalid", out_valid, 0);
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        chk("sb_ovalid", out_valid, 1);
        chk("sb_wen", gpr_wen, 0);
        drain("sb");

        // LH / LHU at lane 2
        issue(OP_IL, 3'b001, 7'h00, 5'd3, 32'h1000, 32'h0, 32'd2, 32'h300);
        chk("lh_addr", mem_req_addr, 32'h1000);
        chk("lh_req_wen", mem_req_wen, 0);
        mem_txn("lh", 32'h8001_0000);
        chk("lh_ovalid", out_valid, 1);
        chk("lh_wdata", gpr_wdata, 32'hFFFF_8001);
        chk("lh_wen", gpr_wen, 1);
        drain("lh");

        issue(OP_IL, 3'b101, 7'h00, 5'd3, 32'h1000, 32'h0, 32'd2, 32'h304);
        mem_txn("lhu", 32'h8001_0000);
        chk("lhu_wdata", gpr_wdata, 32'h0000_8001);
        drain("lhu");

        // LB at lane 3, sign bit clear
        issue(OP_IL, 3'b000, 7'h00, 5'd4, 32'h1000, 32'h0, 32'd3, 32'h308);
        mem_txn("lb", 32'h7F12_3456);
        chk("lb_wdata", gpr_wdata, 32'h0000_007F);
        drain("lb");

        // Misaligned LW
        issue(OP_IL, 3'b010, 7'h00, 5'd3, 32'h1000, 32'h0, 32'd2, 32'h30C);
        chk("lwmis_req", mem_req_valid, 0);
        chk("lwmis_ovalid", out_valid, 1);
        chk("lwmis_flag", misalign, 1);
        chk("lwmis_wen", gpr_wen, 0);
        drain("lwmis");

        // Branches with rs1=-1, rs2=1
        issue(OP_B, 3'b101, 7'h00, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h400);
        chk("bge_jump", jump_en, 0);
        chk("bge_dnpc", dnpc, 32'h404);
        chk("bge_wen", gpr_wen, 0);
        drain("bge");
        issue(OP_B, 3'b110, 7'h00, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h400);
        chk("bltu_jump", jump_en, 0);
        drain("bltu");
        issue(OP_B, 3'b100, 7'h00, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h400);
        chk("blt_jump", jump_en, 1);
        chk("blt_dnpc", dnpc, 32'h440);
        drain("blt");

        // JR clears bit 0
        issue(OP_JR, 3'b000, 7'h00, 5'd1, 32'h2001, 32'h0, 32'd2, 32'h500);
        chk("jr_jump", jump_en, 1);
        chk("jr_dnpc", dnpc, 32'h2002);
        chk("jr_wdata", gpr_wdata, 32'h504);
        drain("jr");

        // AUIPC
        issue(OP_UPC, 3'b000, 7'h00, 5'd2, 32'h0, 32'h0, 32'h1234_5000, 32'h1000);
        chk("auipc_wdata", gpr_wdata, 32'h1234_6000);
        drain("auipc");

        // Unknown opcode behaves as NOP
        issue(7'b1111111, 3'b000, 7'h00, 5'd9, 32'h1, 32'h1, 32'h80, 32'h600);
        chk("nop_wen", gpr_wen, 0);
        chk("nop_dnpc", dnpc, 32'h604);
        chk("nop_jump", jump_en, 0);
        drain("nop");

        // Reset while in MWAIT, then a late response
        issue(OP_IL, 3'b010, 7'h00, 5'd3, 32'h1000, 32'h0, 32'd4, 32'h700);
        chk("rstm_req", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("rstm_in_mwait", in_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstm_ready", in_ready, 1);
        chk("rstm_ovalid", out_valid, 0);
        chk("rstm_req_valid", mem_req_valid, 0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEAD_BEEF;
        step();
        mem_resp_valid = 1'b0;
        chk("rstm_late_ovalid", out_valid, 0);
        chk("rstm_late_ready", in_ready, 1);
        chk("rstm_late_wdata", gpr_wdata, 0);
        step();
        chk("rstm_late_ovalid2", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
